search_table: RTL and testbench

- Sorted key/value lookup table with up to DEPTH entries, holding 16-bit keys and 16-bit results.
- Lookups use a binary search with one probe per cycle.
- A maintenance port supports insert, delete, update and clear; inserts and deletes keep the array sorted by shifting entries.
- Serves as a CAM-like lookup engine beside a request/response controller.

---
 rtl/search_table_pkg.sv | 29 ++
 rtl/search_table_if.sv | 34 +++
 rtl/search_table_bsearch_step.sv | 48 ++++
 rtl/search_table.sv | 244 ++++++++++++++++++++++++
 tb/tb_search_table.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/search_table_pkg.sv
// search_table_pkg: shared definitions for the sorted key/value lookup table.
//   - maintenance opcode constants
//   - controller state encoding
//   - default key/value widths and depth
//   - cnt_width(): width of an entry count that can hold 0..DEPTH
package search_table_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int KEY_W_DEF = 16;
  localparam int VAL_W_DEF = 16;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_DELETE = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SHIFT_UP,
    ST_SHIFT_DOWN,
    ST_FINISH
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/search_table_if.sv
// search_table_if: lookup and maintenance ports of search_table.
//   master : requester side (drives req/search and opReq/opCode/opSearch/opResult)
//   slave  : table side (drives rdy/opRdy/done/found/result/opErr/numEntries)
interface search_table_if
  import search_table_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int VAL_W = VAL_W_DEF,
  parameter int CNT_W = cnt_width(DEPTH_DEF)
);
  logic             req;
  logic [KEY_W-1:0] search;
  logic             opReq;
  logic [1:0]       opCode;
  logic [KEY_W-1:0] opSearch;
  logic [VAL_W-1:0] opResult;
  logic             opRdy;
  logic             rdy;
  logic             found;
  logic             done;
  logic [VAL_W-1:0] result;
  logic             opErr;
  logic [CNT_W-1:0] numEntries;

  modport master (
    output req, search, opReq, opCode, opSearch, opResult,
    input  opRdy, rdy, found, done, result, opErr, numEntries
  );

  modport slave (
    input  req, search, opReq, opCode, opSearch, opResult,
    output opRdy, rdy, found, done, result, opErr, numEntries
  );
endinterface

// File: rtl/search_table_bsearch_step.sv
// search_table_bsearch_step: one combinational binary-search probe.
//   lo, hi   : current signed search bounds (hi = -1 on an empty range)
//   probe    : key stored at index mid (read by the caller)
//   target   : key being searched for
//   mid      : probe index (lo+hi)>>1
//   lo_nxt, hi_nxt : narrowed bounds
//   hit      : probe equals target
//   term     : search is over (hit, or range became/was empty)
module search_table_bsearch_step #(
  parameter int KEY_W = 16,
  parameter int PW    = 12
) (
  input  logic signed [PW-1:0]    lo,
  input  logic signed [PW-1:0]    hi,
  input  logic        [KEY_W-1:0] probe,
  input  logic        [KEY_W-1:0] target,
  output logic signed [PW-1:0]    mid,
  output logic signed [PW-1:0]    lo_nxt,
  output logic signed [PW-1:0]    hi_nxt,
  output logic                    hit,
  output logic                    term
);
  localparam logic signed [PW-1:0] ONE = PW'(1);

  logic signed [PW-1:0] sum;

  always_comb begin
    sum    = lo + hi;
    mid    = sum >>> 1;
    lo_nxt = lo;
    hi_nxt = hi;
    hit    = 1'b0;
    term   = 1'b0;
    if (lo > hi) begin
      // Empty range on entry: only happens for an empty table.
      term = 1'b1;
    end else if (probe == target) begin
      hit  = 1'b1;
      term = 1'b1;
    end else if (probe < target) begin
      lo_nxt = mid + ONE;
      term   = (mid + ONE) > hi;
    end else begin
      hi_nxt = mid - ONE;
      term   = lo > (mid - ONE);
    end
  end
endmodule

// File: rtl/search_table.sv
// search_table: sorted key/value table with binary-search lookup.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; empties the table
//   bus   : search_table_if.slave (lookup req/search, maintenance
//           opReq/opCode/opSearch/opResult, rdy/opRdy/done/found/result/
//           opErr/numEntries)
//   hitCount : lookup-hit counter, present only when
//              SEARCH_TABLE_HIT_COUNT_EN is defined
// Keys are held strictly ascending in keys[0..numEntries-1]; inserts and
// deletes shift one entry per cycle to keep that order.
module search_table
  import search_table_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  search_table_if.slave    bus
`ifdef SEARCH_TABLE_HIT_COUNT_EN
  ,
  output logic [15:0]      hitCount
`endif
);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = CNT_W - 1;
  localparam int PW    = CNT_W + 1;
  localparam logic signed [PW-1:0] ONE = PW'(1);

  state_t state_q, state_d;

  logic [KEY_W-1:0] keys [DEPTH];
  logic [VAL_W-1:0] vals [DEPTH];

  logic [CNT_W-1:0] num_q;
  logic             found_q;
  logic [VAL_W-1:0] result_q;
  logic             err_q;
  logic             is_op_q;

  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [1:0]       op_q;
  logic signed [PW-1:0] lo_q, hi_q;
  logic [CNT_W-1:0] ptr_q, pos_q;

  logic signed [PW-1:0] mid, lo_nxt, hi_nxt;
  logic             hit, term;
  logic [IDX_W-1:0] mid_idx, ptr_idx, pos_idx;
  logic [CNT_W-1:0] mid_cnt;
  logic             full, shift_up_last, shift_down_last;
  logic             unused_mid_sign;

  assign mid_idx         = mid[IDX_W-1:0];
  assign mid_cnt         = mid[CNT_W-1:0];
  assign unused_mid_sign = mid[PW-1];
  assign ptr_idx         = ptr_q[IDX_W-1:0];
  assign pos_idx         = pos_q[IDX_W-1:0];
  assign full            = (num_q == CNT_W'(DEPTH));
  assign shift_up_last   = (ptr_q == pos_q);
  assign shift_down_last = ((ptr_q + CNT_W'(1)) >= num_q);

  search_table_bsearch_step #(
    .KEY_W (KEY_W),
    .PW    (PW)
  ) u_step (
    .lo     (lo_q),
    .hi     (hi_q),
    .probe  (keys[mid_idx]),
    .target (key_q),
    .mid    (mid),
    .lo_nxt (lo_nxt),
    .hi_nxt (hi_nxt),
    .hit    (hit),
    .term   (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.opReq) begin
          if (bus.opCode == OP_CLEAR || (bus.opCode == OP_INSERT && full))
            state_d = ST_FINISH;
          else
            state_d = ST_SEARCH;
        end else if (bus.req) begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (term) begin
          if (!is_op_q)                state_d = ST_FINISH;
          else if (op_q == OP_INSERT)  state_d = hit ? ST_FINISH : ST_SHIFT_UP;
          else if (op_q == OP_DELETE)  state_d = hit ? ST_SHIFT_DOWN : ST_FINISH;
          else                         state_d = ST_FINISH;
        end
      end
      ST_SHIFT_UP:   if (shift_up_last)   state_d = ST_FINISH;
      ST_SHIFT_DOWN: if (shift_down_last) state_d = ST_FINISH;
      ST_FINISH:     state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Control and result registers: reset, and only changed on the way to FINISH
  // so found/result/opErr hold steady between done pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q    <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      is_op_q  <= 1'b0;
`ifdef SEARCH_TABLE_HIT_COUNT_EN
      hitCount <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.opReq) begin
            is_op_q <= 1'b1;
            if (bus.opCode == OP_CLEAR) begin
              num_q    <= '0;
              found_q  <= 1'b0;
              result_q <= '0;
              err_q    <= 1'b0;
`ifdef SEARCH_TABLE_HIT_COUNT_EN
              hitCount <= '0;
`endif
            end else if (bus.opCode == OP_INSERT && full) begin
              found_q  <= 1'b0;
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end else if (bus.req) begin
            is_op_q <= 1'b0;
          end
        end
        ST_SEARCH: begin
          if (term) begin
            if (!is_op_q) begin
              found_q  <= hit;
              result_q <= hit ? vals[mid_idx] : '0;
`ifdef SEARCH_TABLE_HIT_COUNT_EN
              if (hit && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
`endif
            end else if (op_q == OP_INSERT) begin
              if (hit) begin
                found_q  <= 1'b0;
                result_q <= '0;
                err_q    <= 1'b1;
              end
            end else if (op_q == OP_DELETE) begin
              if (!hit) begin
                found_q  <= 1'b0;
                result_q <= '0;
                err_q    <= 1'b1;
              end
            end else begin
              found_q  <= 1'b0;
              result_q <= '0;
              err_q    <= !hit;
            end
          end
        end
        ST_SHIFT_UP: begin
          if (shift_up_last) begin
            num_q    <= num_q + CNT_W'(1);
            found_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
          end
        end
        ST_SHIFT_DOWN: begin
          if (shift_down_last) begin
            num_q    <= num_q - CNT_W'(1);
            found_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: latched request, search bounds, shift pointers and the array.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        key_q <= bus.opReq ? bus.opSearch : bus.search;
        val_q <= bus.opResult;
        op_q  <= bus.opCode;
        lo_q  <= '0;
        hi_q  <= $signed({1'b0, num_q}) - ONE;
      end
      ST_SEARCH: begin
        lo_q <= lo_nxt;
        hi_q <= hi_nxt;
        if (term) begin
          // Insert shifts from slot n down to the insertion point;
          // delete shifts from the hit slot upward.
          pos_q <= lo_nxt[CNT_W-1:0];
          ptr_q <= (op_q == OP_DELETE) ? mid_cnt : num_q;
          if (is_op_q && hit && op_q == OP_UPDATE) vals[mid_idx] <= val_q;
        end
      end
      ST_SHIFT_UP: begin
        if (shift_up_last) begin
          keys[pos_idx] <= key_q;
          vals[pos_idx] <= val_q;
        end else begin
          keys[ptr_idx] <= keys[ptr_idx - IDX_W'(1)];
          vals[ptr_idx] <= vals[ptr_idx - IDX_W'(1)];
          ptr_q         <= ptr_q - CNT_W'(1);
        end
      end
      ST_SHIFT_DOWN: begin
        if (!shift_down_last) begin
          keys[ptr_idx] <= keys[ptr_idx + IDX_W'(1)];
          vals[ptr_idx] <= vals[ptr_idx + IDX_W'(1)];
          ptr_q         <= ptr_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.rdy        = (state_q == ST_IDLE);
  assign bus.opRdy      = (state_q == ST_IDLE);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.found      = found_q;
  assign bus.result     = result_q;
  assign bus.opErr      = err_q;
  assign bus.numEntries = num_q;

endmodule

// File: tb/tb_search_table.sv
// tb_search_table: directed table-driven bench for search_table.
// Builds with or without SEARCH_TABLE_HIT_COUNT_EN.
module tb_search_table;
  import search_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  search_table_if #(.KEY_W(16), .VAL_W(16), .CNT_W(11)) bus ();

`ifdef SEARCH_TABLE_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  search_table #(.DEPTH(1024), .KEY_W(16), .VAL_W(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef SEARCH_TABLE_HIT_COUNT_EN
    ,
    .hitCount (hit_count)
`endif
  );

  typedef struct {
    bit          is_op;
    logic [1:0]  code;
    logic [15:0] key;
    logic [15:0] val;
    logic        exp_found;
    logic [15:0] exp_result;
    logic        exp_err;
    logic [10:0] exp_num;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit is_op, input logic [1:0] code, input logic [15:0] key,
                              input logic [15:0] val, input logic f, input logic [15:0] r,
                              input logic e, input logic [10:0] n);
    vec_t v;
    v.is_op = is_op; v.code = code; v.key = key; v.val = val;
    v.exp_found = f; v.exp_result = r; v.exp_err = e; v.exp_num = n;
    return v;
  endfunction

  // Drive one transaction for a single cycle and wait (bounded) for done.
  task automatic run_txn(input bit is_op, input logic [1:0] code, input logic [15:0] key,
                         input logic [15:0] val, input bit also_req, output bit ok);
    @(negedge clk);
    bus.opReq    = is_op;
    bus.req      = !is_op || also_req;
    bus.opCode   = code;
    bus.opSearch = key;
    bus.opResult = val;
    bus.search   = key;
    @(posedge clk);
    #1;
    bus.opReq = 1'b0;
    bus.req   = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 4000 cycles (key 0x%0h)", key);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    bit ok;
    run_txn(v.is_op, v.code, v.key, v.val, 1'b0, ok);
    if (ok) begin
      chk({tag, " found"},  32'(bus.found),      32'(v.exp_found));
      chk({tag, " result"}, 32'(bus.result),     32'(v.exp_result));
      chk({tag, " opErr"},  32'(bus.opErr),      32'(v.exp_err));
      chk({tag, " num"},    32'(bus.numEntries), 32'(v.exp_num));
    end
  endtask

  initial begin
    bit ok;
    int fill_err;

    bus.req = 0; bus.search = 0; bus.opReq = 0; bus.opCode = 0;
    bus.opSearch = 0; bus.opResult = 0;

    vecs.push_back(mk(0, OP_INSERT, 16'h28, 16'h00, 0, 16'h00, 0, 0));
    vecs.push_back(mk(1, OP_INSERT, 16'h96, 16'h68, 0, 16'h00, 0, 1));
    vecs.push_back(mk(1, OP_INSERT, 16'h84, 16'h01, 0, 16'h00, 0, 2));
    vecs.push_back(mk(1, OP_INSERT, 16'h97, 16'h02, 0, 16'h00, 0, 3));
    vecs.push_back(mk(1, OP_INSERT, 16'h57, 16'h03, 0, 16'h00, 0, 4));
    vecs.push_back(mk(1, OP_INSERT, 16'h01, 16'h04, 0, 16'h00, 0, 5));
    vecs.push_back(mk(0, OP_INSERT, 16'h57, 16'h00, 1, 16'h03, 0, 5));
    vecs.push_back(mk(0, OP_INSERT, 16'h23, 16'h00, 0, 16'h00, 0, 5));
    vecs.push_back(mk(0, OP_INSERT, 16'h97, 16'h00, 1, 16'h02, 0, 5));
    vecs.push_back(mk(0, OP_INSERT, 16'h01, 16'h00, 1, 16'h04, 0, 5));
    vecs.push_back(mk(1, OP_INSERT, 16'h84, 16'h77, 0, 16'h00, 1, 5));
    vecs.push_back(mk(0, OP_INSERT, 16'h84, 16'h00, 1, 16'h01, 1, 5));
    vecs.push_back(mk(1, OP_DELETE, 16'h57, 16'h00, 0, 16'h00, 0, 4));
    vecs.push_back(mk(0, OP_INSERT, 16'h57, 16'h00, 0, 16'h00, 0, 4));
    vecs.push_back(mk(1, OP_UPDATE, 16'h01, 16'h89, 0, 16'h00, 0, 4));
    vecs.push_back(mk(0, OP_INSERT, 16'h01, 16'h00, 1, 16'h89, 0, 4));
    vecs.push_back(mk(1, OP_DELETE, 16'h99, 16'h00, 0, 16'h00, 1, 4));
    vecs.push_back(mk(0, OP_INSERT, 16'h96, 16'h00, 1, 16'h68, 1, 4));
    vecs.push_back(mk(1, OP_DELETE, 16'h01, 16'h00, 0, 16'h00, 0, 3));
    vecs.push_back(mk(0, OP_INSERT, 16'h84, 16'h00, 1, 16'h01, 0, 3));
    vecs.push_back(mk(0, OP_INSERT, 16'h97, 16'h00, 1, 16'h02, 0, 3));
    vecs.push_back(mk(1, OP_UPDATE, 16'h55, 16'h11, 0, 16'h00, 1, 3));

    repeat (3) @(negedge clk);
    chk("reset rdy",   32'(bus.rdy),   32'd1);
    chk("reset opRdy", 32'(bus.opRdy), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset rdy",        32'(bus.rdy),        32'd1);
    chk("reset opRdy",      32'(bus.opRdy),      32'd1);
    chk("reset done",       32'(bus.done),       32'd0);
    chk("reset found",      32'(bus.found),      32'd0);
    chk("reset result",     32'(bus.result),     32'd0);
    chk("reset opErr",      32'(bus.opErr),      32'd0);
    chk("reset numEntries", 32'(bus.numEntries), 32'd0);

    // Empty-table lookup: one SEARCH cycle, then done.
    bus.req = 1'b1; bus.search = 16'h28;
    @(posedge clk); #1; bus.req = 1'b0;
    @(negedge clk);
    chk("empty busy rdy", 32'(bus.rdy),  32'd0);
    chk("empty no done",  32'(bus.done), 32'd0);
    @(negedge clk);
    chk("empty done",   32'(bus.done),  32'd1);
    chk("empty found",  32'(bus.found), 32'd0);
    chk("empty result", 32'(bus.result), 32'd0);
    @(negedge clk);
    chk("done pulse one cycle", 32'(bus.done), 32'd0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // opReq and req together: the insert wins, the lookup is dropped.
    run_txn(1'b1, OP_INSERT, 16'h50, 16'h55, 1'b1, ok);
    if (ok) begin
      chk("prio found",  32'(bus.found),      32'd0);
      chk("prio result", 32'(bus.result),     32'd0);
      chk("prio opErr",  32'(bus.opErr),      32'd0);
      chk("prio num",    32'(bus.numEntries), 32'd4);
    end
    repeat (3) begin
      @(negedge clk);
      chk("prio no second done", 32'(bus.done), 32'd0);
    end
    apply(mk(0, OP_INSERT, 16'h50, 16'h00, 1, 16'h55, 0, 4), "prio lookup");

    // Fill to capacity with ascending keys.
    apply(mk(1, OP_CLEAR, 16'h00, 16'h00, 0, 16'h00, 0, 0), "clear1");
    fill_err = 0;
    for (int k = 0; k < 1024; k++) begin
      run_txn(1'b1, OP_INSERT, 16'(k), 16'(k) ^ 16'h5A5A, 1'b0, ok);
      if (!ok || bus.opErr) fill_err++;
    end
    chk("fill errors", 32'(fill_err), 32'd0);
    chk("fill num",    32'(bus.numEntries), 32'd1024);
    apply(mk(0, OP_INSERT, 16'h03FF, 16'h0, 1, 16'h59A5, 0, 1024), "full hi");
    apply(mk(0, OP_INSERT, 16'h0000, 16'h0, 1, 16'h5A5A, 0, 1024), "full lo");
    apply(mk(0, OP_INSERT, 16'h0200, 16'h0, 1, 16'h585A, 0, 1024), "full mid");
    apply(mk(0, OP_INSERT, 16'h0400, 16'h0, 0, 16'h0000, 0, 1024), "full miss");
    apply(mk(1, OP_INSERT, 16'h5000, 16'h1, 0, 16'h0000, 1, 1024), "overflow");
    apply(mk(1, OP_CLEAR,  16'h0000, 16'h0, 0, 16'h0000, 0, 0),    "clear2");
    apply(mk(0, OP_INSERT, 16'h0200, 16'h0, 0, 16'h0000, 0, 0),    "after clear");

    // Reset while an insert is shifting.
    apply(mk(1, OP_INSERT, 16'h10, 16'h1, 0, 16'h0, 0, 1), "pre10");
    apply(mk(1, OP_INSERT, 16'h20, 16'h2, 0, 16'h0, 0, 2), "pre20");
    apply(mk(1, OP_INSERT, 16'h30, 16'h3, 0, 16'h0, 0, 3), "pre30");
    @(negedge clk);
    bus.opReq = 1'b1; bus.opCode = OP_INSERT; bus.opSearch = 16'h05; bus.opResult = 16'h9;
    @(posedge clk); #1; bus.opReq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("shift busy rdy", 32'(bus.rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset num",   32'(bus.numEntries), 32'd0);
    chk("midreset rdy",   32'(bus.rdy),        32'd1);
    chk("midreset opRdy", 32'(bus.opRdy),      32'd1);
    chk("midreset done",  32'(bus.done),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, OP_INSERT, 16'h10, 16'h0, 0, 16'h0, 0, 0), "post reset");
`ifdef SEARCH_TABLE_HIT_COUNT_EN
    chk("hitCount after reset", 32'(hit_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
